// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundle between the LC-3 operate-instruction sequencer and its environment
//   (instruction fetch on one side, register file / ALU datapath on the other).
//
//   Optional feature macro: ALU_SEQ_ILLEGAL_EN (adds the illegal_op pulse).
//
//   Signals
//     ir_in[15:0]       fetch -> seq   instruction word
//     ir_valid          fetch -> seq   ir_in valid, held until accepted
//     ir_ready          seq -> fetch   sequencer can accept (IDLE only)
//     ir_out[15:0]      seq -> ALU     latched IR (ALU takes imm5 from it)
//     sr1_addr[2:0]     seq -> RF      read port A = IR[8:6]
//     sr2_addr[2:0]     seq -> RF      read port B = IR[2:0]
//     sr2mux_ctrl       seq -> ALU     1 = imm5, 0 = SR2
//     alumux_ctrl[1:0]  seq -> ALU     00 ADD, 01 AND, 10 NOT, 11 pass SR1
//     alu_result[15:0]  ALU -> seq     ALU output
//     dr_addr[2:0]      seq -> RF      write-back address = IR[11:9]
//     dr_data[15:0]     seq -> RF      write-back data
//     dr_we             seq -> RF      one-cycle write strobe
//     nzp[2:0]          seq -> core    condition codes {N,Z,P}
//     done              seq -> core    one-cycle retire pulse
//     illegal_op        seq -> core    one-cycle pulse (macro builds only)
//
//   Modports: master = sequencer side, slave = environment side.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if;
    logic [15:0] ir_in;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_out;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic        sr2mux_ctrl;
    logic [1:0]  alumux_ctrl;
    logic [15:0] alu_result;
    logic [2:0]  dr_addr;
    logic [15:0] dr_data;
    logic        dr_we;
    logic [2:0]  nzp;
    logic        done;
`ifdef ALU_SEQ_ILLEGAL_EN
    logic        illegal_op;
`endif

    modport master (
`ifdef ALU_SEQ_ILLEGAL_EN
        output illegal_op,
`endif
        input  ir_in,
        input  ir_valid,
        input  alu_result,
        output ir_ready,
        output ir_out,
        output sr1_addr,
        output sr2_addr,
        output sr2mux_ctrl,
        output alumux_ctrl,
        output dr_addr,
        output dr_data,
        output dr_we,
        output nzp,
        output done
    );

    modport slave (
`ifdef ALU_SEQ_ILLEGAL_EN
        input  illegal_op,
`endif
        output ir_in,
        output ir_valid,
        output alu_result,
        input  ir_ready,
        input  ir_out,
        input  sr1_addr,
        input  sr2_addr,
        input  sr2mux_ctrl,
        input  alumux_ctrl,
        input  dr_addr,
        input  dr_data,
        input  dr_we,
        input  nzp,
        input  done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Control side of the LC-3 operate instructions (ADD, AND, NOT). Accepts one
//   instruction over a valid/ready handshake, drives the ALU and register-file
//   controls for one execute cycle, captures the ALU result, writes it back and
//   updates the NZP condition codes. One instruction per three cycles at best.
//
//   Optional feature macro: ALU_SEQ_ILLEGAL_EN
//     defined   : non-operate opcodes pulse illegal_op together with done.
//     undefined : such opcodes retire silently (done only).
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_op_sequencer_if.master (handshake, ALU/RF controls, status)
//
//   States
//     state  | meaning
//     -------+-----------------------------------------------------------
//     IDLE   | ir_ready high, waiting for ir_valid
//     EXEC   | ALU controls decoded from ir_q, alu_result captured
//     WB     | write-back strobe and done pulse; NZP updated on exit
// -----------------------------------------------------------------------------
module alu_op_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUMUX_ADD  = 2'b00;
    localparam logic [1:0] ALUMUX_AND  = 2'b01;
    localparam logic [1:0] ALUMUX_NOT  = 2'b10;
    localparam logic [1:0] ALUMUX_PASS = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] ir_q,    ir_d;
    logic [15:0] res_q,   res_d;
    logic [2:0]  nzp_q,   nzp_d;

    logic        op_legal;
    logic [1:0]  dec_alumux;
    logic        dec_sr2mux;

    logic [1:0]  alumux;
    logic        sr2mux;
    logic        dr_we;
    logic        done;
`ifdef ALU_SEQ_ILLEGAL_EN
    logic        illegal_op;
`endif

    // Opcode decode; only meaningful while in EXEC/WB but kept free-running.
    always_comb begin
        op_legal   = 1'b0;
        dec_alumux = ALUMUX_PASS;
        dec_sr2mux = 1'b0;
        case (ir_q[15:12])
            OP_ADD: begin
                op_legal   = 1'b1;
                dec_alumux = ALUMUX_ADD;
                dec_sr2mux = ir_q[5];
            end
            OP_AND: begin
                op_legal   = 1'b1;
                dec_alumux = ALUMUX_AND;
                dec_sr2mux = ir_q[5];
            end
            OP_NOT: begin
                op_legal   = 1'b1;
                dec_alumux = ALUMUX_NOT;
            end
            default: begin
                op_legal   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        res_d   = res_q;
        nzp_d   = nzp_q;
        alumux  = ALUMUX_PASS;
        sr2mux  = 1'b0;
        dr_we   = 1'b0;
        done    = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_EN
        illegal_op = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // ir_ready is high throughout IDLE, so valid alone completes
                // the handshake here.
                if (bus.ir_valid) begin
                    ir_d    = bus.ir_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alumux  = dec_alumux;
                sr2mux  = dec_sr2mux;
                res_d   = bus.alu_result;
                state_d = S_WB;
            end
            S_WB: begin
                done = 1'b1;
                if (op_legal) begin
                    dr_we = 1'b1;
                    // Exactly one of N/Z/P is set.
                    nzp_d = {res_q[15], (res_q == 16'h0000),
                             (!res_q[15] && (res_q != 16'h0000))};
                end
`ifdef ALU_SEQ_ILLEGAL_EN
                else begin
                    illegal_op = 1'b1;
                end
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset mid-instruction drops the instruction: state returns to IDLE, so
    // the WB strobe never fires, and the condition codes go back to Z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            res_q   <= 16'h0000;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            nzp_q   <= nzp_d;
        end
    end

    assign bus.ir_ready    = (state_q == S_IDLE);
    assign bus.ir_out      = ir_q;
    assign bus.sr1_addr    = ir_q[8:6];
    assign bus.sr2_addr    = ir_q[2:0];
    assign bus.sr2mux_ctrl = sr2mux;
    assign bus.alumux_ctrl = alumux;
    assign bus.dr_addr     = ir_q[11:9];
    assign bus.dr_data     = res_q;
    assign bus.dr_we       = dr_we;
    assign bus.nzp         = nzp_q;
    assign bus.done        = done;
`ifdef ALU_SEQ_ILLEGAL_EN
    assign bus.illegal_op  = illegal_op;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_op_sequencer_if sif ();

    alu_op_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the in-flight instruction by how many edges
    // have passed since it was accepted (0 = nothing in flight).
    int          m_age;
    logic [15:0] m_ir;
    logic [15:0] m_res;
    logic [2:0]  m_nzp;
    bit          m_took;

    function automatic bit is_legal(input logic [15:0] ir);
        return (ir[15:12] == 4'h1) || (ir[15:12] == 4'h5) || (ir[15:12] == 4'h9);
    endfunction

    function automatic logic [1:0] exp_alumux(input logic [15:0] ir);
        if (ir[15:12] == 4'h1) return 2'b00;
        if (ir[15:12] == 4'h5) return 2'b01;
        if (ir[15:12] == 4'h9) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic exp_sr2mux(input logic [15:0] ir);
        if (ir[15:12] == 4'h1 || ir[15:12] == 4'h5) return ir[5];
        return 1'b0;
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age  = 0;
        m_ir   = 16'h0000;
        m_res  = 16'h0000;
        m_nzp  = 3'b010;
        m_took = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_took = 1'b0;
            if (m_age == 0) begin
                if (sif.ir_valid) begin
                    m_ir   = sif.ir_in;
                    m_age  = 1;
                    m_took = 1'b1;
                end
            end else if (m_age == 1) begin
                m_res = sif.alu_result;
                m_age = 2;
            end else begin
                if (is_legal(m_ir)) m_nzp = nzp_of(m_res);
                m_age = 0;
            end
        end
    endtask

    task automatic check_all();
        bit exec, wb, legal;
        exec  = (m_age == 1);
        wb    = (m_age == 2);
        legal = is_legal(m_ir);
        chk("ir_ready", 32'(sif.ir_ready), 32'(m_age == 0));
        chk("ir_out",   32'(sif.ir_out),   32'(m_ir));
        chk("sr1_addr", 32'(sif.sr1_addr), 32'(m_ir[8:6]));
        chk("sr2_addr", 32'(sif.sr2_addr), 32'(m_ir[2:0]));
        chk("dr_addr",  32'(sif.dr_addr),  32'(m_ir[11:9]));
        chk("alumux",   32'(sif.alumux_ctrl), exec ? 32'(exp_alumux(m_ir)) : 32'd3);
        chk("sr2mux",   32'(sif.sr2mux_ctrl), exec ? 32'(exp_sr2mux(m_ir)) : 32'd0);
        chk("dr_we",    32'(sif.dr_we),    32'(wb && legal));
        chk("done",     32'(sif.done),     32'(wb));
        if (wb && legal) chk("dr_data", 32'(sif.dr_data), 32'(m_res));
        chk("nzp",      32'(sif.nzp),      32'(m_nzp));
`ifdef ALU_SEQ_ILLEGAL_EN
        chk("illegal_op", 32'(sif.illegal_op), 32'(wb && !legal));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // One instruction from accept to retire with hand-computed expectations.
    task automatic run_op(input logic [15:0] ir, input logic [15:0] alu,
                          input logic [2:0] e_sr1, input logic [1:0] e_alumux,
                          input logic e_sr2mux, input logic [2:0] e_dr,
                          input logic e_we, input logic [2:0] e_nzp);
        sif.ir_valid = 1'b1;
        sif.ir_in    = ir;
        step();
        chk("lit took", 32'(m_took), 32'd1);
        sif.ir_valid   = 1'b0;
        sif.alu_result = alu;
        chk("lit exec ready",  32'(sif.ir_ready),    32'd0);
        chk("lit exec sr1",    32'(sif.sr1_addr),    32'(e_sr1));
        chk("lit exec alumux", 32'(sif.alumux_ctrl), 32'(e_alumux));
        chk("lit exec sr2mux", 32'(sif.sr2mux_ctrl), 32'(e_sr2mux));
        step();
        chk("lit wb dr_we",  32'(sif.dr_we),   32'(e_we));
        chk("lit wb done",   32'(sif.done),    32'd1);
        chk("lit wb dr_addr", 32'(sif.dr_addr), 32'(e_dr));
        if (e_we) chk("lit wb dr_data", 32'(sif.dr_data), 32'(alu));
`ifdef ALU_SEQ_ILLEGAL_EN
        chk("lit wb illegal", 32'(sif.illegal_op), 32'(!e_we));
`endif
        step();
        chk("lit nzp",       32'(sif.nzp),      32'(e_nzp));
        chk("lit model nzp", 32'(m_nzp),        32'(e_nzp));
        chk("lit idle ready", 32'(sif.ir_ready), 32'd1);
    endtask

    function automatic logic [15:0] rand_ir();
        logic [31:0] r;
        logic [3:0]  op;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: op = 4'h1;
            1: op = 4'h5;
            2: op = 4'h9;
            default: op = r[15:12];
        endcase
        return {op, r[11:0]};
    endfunction

    function automatic logic [15:0] rand_alu();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'h8000 | r[15:0];
            default: return r[15:0];
        endcase
    endfunction

    initial begin
        sif.ir_valid   = 1'b0;
        sif.ir_in      = 16'h0000;
        sif.alu_result = 16'h0000;
        rst_n          = 1'b0;
        model_reset();

        // Reset state, including outputs while reset is held.
        @(negedge clk);
        check_all();
        chk("rst ready",  32'(sif.ir_ready),    32'd1);
        chk("rst alumux", 32'(sif.alumux_ctrl), 32'd3);
        chk("rst sr2mux", 32'(sif.sr2mux_ctrl), 32'd0);
        chk("rst nzp",    32'(sif.nzp),         32'd2);
        chk("rst dr_we",  32'(sif.dr_we),       32'd0);
        chk("rst done",   32'(sif.done),        32'd0);
        // A valid held during reset must not be taken.
        sif.ir_valid = 1'b1;
        sif.ir_in    = 16'h12BD;
        step();
        chk("rst no accept", 32'(sif.ir_ready), 32'd1);
        sif.ir_valid = 1'b0;
        #2 rst_n = 1'b1;

        run_op(16'h12BD, 16'h0004, 3'd2, 2'b00, 1'b1, 3'd1, 1'b1, 3'b001);
        run_op(16'h5705, 16'h0000, 3'd4, 2'b01, 1'b0, 3'd3, 1'b1, 3'b010);
        chk("lit and sr2", 32'(sif.sr2_addr), 32'd5);
        run_op(16'h9DFF, 16'h8000, 3'd7, 2'b10, 1'b0, 3'd6, 1'b1, 3'b100);
        run_op(16'h0E05, 16'h1234, 3'd0, 2'b11, 1'b0, 3'd7, 1'b0, 3'b100);

        // Reset during EXEC aborts the instruction.
        sif.ir_valid = 1'b1;
        sif.ir_in    = 16'h12BD;
        step();
        sif.ir_valid   = 1'b0;
        sif.alu_result = 16'h0004;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("abort nzp",   32'(sif.nzp),      32'd2);
        chk("abort ready", 32'(sif.ir_ready), 32'd1);
        chk("abort dr_we", 32'(sif.dr_we),    32'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        run_op(16'h12BD, 16'h0004, 3'd2, 2'b00, 1'b1, 3'd1, 1'b1, 3'b001);

        // ir_valid held high across two instructions.
        sif.ir_valid = 1'b1;
        sif.ir_in    = 16'h12BD;
        step();                                       // accept, cycle 0
        sif.ir_in      = 16'h5705;
        sif.alu_result = 16'h0004;
        chk("b2b c1 ready", 32'(sif.ir_ready), 32'd0);
        step();                                       // cycle 2
        chk("b2b c2 ready", 32'(sif.ir_ready), 32'd0);
        chk("b2b c2 dr_we", 32'(sif.dr_we),    32'd1);
        step();                                       // cycle 3
        chk("b2b c3 ready", 32'(sif.ir_ready), 32'd1);
        step();                                       // accepted at cycle 3
        chk("b2b took2", 32'(m_took), 32'd1);
        sif.ir_valid   = 1'b0;
        sif.alu_result = 16'h0000;
        step();                                       // cycle 5
        chk("b2b c5 dr_we", 32'(sif.dr_we),   32'd1);
        chk("b2b c5 data",  32'(sif.dr_data), 32'd0);
        step();
        chk("b2b nzp", 32'(sif.nzp), 32'd2);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if (!sif.ir_valid || m_took) begin
                sif.ir_valid = 1'($urandom_range(0, 1));
                sif.ir_in    = rand_ir();
            end
            sif.alu_result = rand_alu();
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all();
                step();
                #2 rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
